// File: rtl/sched_pkg.sv
// Shared types for the tick event scheduler: default sizes, FSM state
// encoding and the per-channel timer record.
package sched_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int PER_W_DEF  = 8;
  localparam int CH_W_DEF   = $clog2(NUM_CH_DEF);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_OFFER = 1'b1
  } sched_state_t;

  // Per-channel timer record at the default period width.
  typedef struct packed {
    logic [PER_W_DEF-1:0] period;
    logic [PER_W_DEF-1:0] count;
    logic                 enable;
  } ch_rec_t;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first requesting index
// strictly after 'last', wrapping around, plus an any-request flag.
module rr_picker #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [W-1:0] grant,
  output logic         any_req
);

  logic [W-1:0] idx;

  // Scan from the farthest offset down so the nearest request overwrites.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_req = |req;
    for (int k = N; k >= 1; k--) begin
      idx = W'((int'(last) + k) % N);
      if (req[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/tick_event_scheduler.sv
// Periodic event scheduler: one programmable down-counter per channel,
// expiries queued as pending bits and issued one at a time over
// valid/ready with round-robin fairness. Sticky overrun per channel.
// Optional feature: define SCHED_TURBO_EN to add a 'turbo' input that
// reloads counters with period>>2 (about 4x faster).
module tick_event_scheduler
  import sched_pkg::*;
#(
  parameter  int NUM_CH = NUM_CH_DEF,
  parameter  int PER_W  = PER_W_DEF,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [PER_W-1:0]  cfg_period,
  input  logic              cfg_enable,
  input  logic              clear_overrun,
`ifdef SCHED_TURBO_EN
  input  logic              turbo,
`endif
  output logic              ev_valid,
  output logic [CH_W-1:0]   ev_ch,
  input  logic              ev_ready,
  output logic [NUM_CH-1:0] active,
  output logic [NUM_CH-1:0] overrun
);

  logic [NUM_CH-1:0][PER_W-1:0] period_r;
  logic [NUM_CH-1:0][PER_W-1:0] count_r;
  logic [NUM_CH-1:0]            enable_r;
  logic [NUM_CH-1:0]            pending_r;

  sched_state_t    state;
  logic [CH_W-1:0] rr_ptr;

  logic [CH_W-1:0]   pick_last;
  logic [CH_W-1:0]   pick_ch;
  logic              pick_any;
  logic              handshake;
  logic              take;
  logic              turbo_on;
  logic [NUM_CH-1:0] wr_sel;
  logic [NUM_CH-1:0] pick_clr;
  logic [NUM_CH-1:0] expire;

`ifdef SCHED_TURBO_EN
  assign turbo_on = turbo;
`else
  assign turbo_on = 1'b0;
`endif

  // Period 0 runs as period 1.
  function automatic logic [PER_W-1:0] eff(input logic [PER_W-1:0] p);
    return (p == '0) ? PER_W'(1) : p;
  endfunction

  function automatic logic [PER_W-1:0] reload(input logic [PER_W-1:0] p,
                                               input logic              fast);
    return fast ? eff(p >> 2) : eff(p);
  endfunction

  assign active    = enable_r;
  assign handshake = (state == S_OFFER) && ev_ready;
  // While offering, the next pick continues after the channel being accepted.
  assign pick_last = (state == S_OFFER) ? ev_ch : rr_ptr;
  assign take      = pick_any && ((state == S_IDLE) || handshake);

  rr_picker #(.N(NUM_CH), .W(CH_W)) u_pick (
    .req     (pending_r),
    .last    (pick_last),
    .grant   (pick_ch),
    .any_req (pick_any)
  );

  // Per-channel decode: cfg target, bit being issued, and tick expiry.
  always_comb begin
    wr_sel   = '0;
    pick_clr = '0;
    expire   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_sel[i]   = cfg_we && (cfg_ch == CH_W'(i));
      pick_clr[i] = take && (pick_ch == CH_W'(i));
      expire[i]   = tick && enable_r[i] && !wr_sel[i] && (count_r[i] <= PER_W'(1));
    end
  end

  // Channel counters, pending bits and sticky overrun flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_r  <= '0;
      count_r   <= '0;
      enable_r  <= '0;
      pending_r <= '0;
      overrun   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_sel[i]) begin
          period_r[i] <= cfg_period;
          enable_r[i] <= cfg_enable;
          count_r[i]  <= reload(cfg_period, turbo_on);
        end else if (tick && enable_r[i]) begin
          count_r[i]  <= expire[i] ? reload(period_r[i], turbo_on)
                                   : count_r[i] - PER_W'(1);
        end
        // A bit being issued this edge is gone, so a re-expiry just re-pends it.
        pending_r[i] <= !wr_sel[i] && ((pending_r[i] && !pick_clr[i]) || expire[i]);
        overrun[i]   <= (overrun[i] && !clear_overrun) ||
                        (expire[i] && pending_r[i] && !pick_clr[i]);
      end
    end
  end

  // Issue FSM: offer one channel at a time, back-to-back while work remains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_IDLE;
      ev_valid <= 1'b0;
      ev_ch    <= '0;
      rr_ptr   <= CH_W'(NUM_CH - 1);
    end else begin
      if (handshake) rr_ptr <= ev_ch;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            ev_ch    <= pick_ch;
            ev_valid <= 1'b1;
            state    <= S_OFFER;
          end
        end
        S_OFFER: begin
          if (ev_ready) begin
            if (pick_any) begin
              ev_ch <= pick_ch;
            end else begin
              ev_valid <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end
        default: begin
          ev_valid <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_event_scheduler.sv
// Bench for tick_event_scheduler: directed scenarios followed by random
// traffic, all compared every cycle against a tick-count reference model.
module tb_tick_event_scheduler;
  import sched_pkg::*;

  localparam int NUM_CH = 4;
  localparam int PER_W  = 8;
  localparam int CH_W   = 2;

  logic              clk = 1'b0;
  logic              reset, tick, cfg_we, cfg_enable, clear_overrun, ev_ready;
  logic [CH_W-1:0]   cfg_ch;
  logic [PER_W-1:0]  cfg_period;
  logic              ev_valid;
  logic [CH_W-1:0]   ev_ch;
  logic [NUM_CH-1:0] active, overrun;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int              m_per  [NUM_CH];
  int              m_left [NUM_CH];
  bit [NUM_CH-1:0] m_en, m_pend, m_ovr;
  bit              m_valid;
  int              m_ch, m_last;

  always #5 clk = ~clk;

  tick_event_scheduler dut (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .cfg_we        (cfg_we),
    .cfg_ch        (cfg_ch),
    .cfg_period    (cfg_period),
    .cfg_enable    (cfg_enable),
    .clear_overrun (clear_overrun),
`ifdef SCHED_TURBO_EN
    .turbo         (1'b0),
`endif
    .ev_valid      (ev_valid),
    .ev_ch         (ev_ch),
    .ev_ready      (ev_ready),
    .active        (active),
    .overrun       (overrun)
  );

  function automatic int eff(input int p);
    return (p == 0) ? 1 : p;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_per[i]  = 0;
      m_left[i] = 0;
    end
    m_en = '0; m_pend = '0; m_ovr = '0;
    m_valid = 0; m_ch = 0; m_last = NUM_CH - 1;
  endtask

  // One clock edge of the reference, using the inputs present at that edge.
  task automatic model_edge();
    bit hs, picked;
    int base, pick;
    hs = m_valid && ev_ready;
    picked = 0; pick = 0;
    if (!m_valid || hs) begin
      base = hs ? m_ch : m_last;
      for (int k = 1; k <= NUM_CH; k++)
        if (!picked && m_pend[(base + k) % NUM_CH]) begin
          picked = 1;
          pick = (base + k) % NUM_CH;
        end
    end
    if (clear_overrun) m_ovr = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      bit ex;
      ex = 0;
      if (picked && pick == i) m_pend[i] = 0;
      if (cfg_we && cfg_ch == i) begin
        m_per[i] = cfg_period; m_en[i] = cfg_enable;
        m_left[i] = eff(cfg_period); m_pend[i] = 0;
      end else if (tick && m_en[i]) begin
        if (m_left[i] <= 1) begin ex = 1; m_left[i] = eff(m_per[i]); end
        else m_left[i]--;
      end
      if (ex) begin
        if (m_pend[i]) m_ovr[i] = 1;
        m_pend[i] = 1;
      end
    end
    if (hs) m_last = m_ch;
    if (picked) begin m_valid = 1; m_ch = pick; end
    else if (hs) m_valid = 0;
  endtask

  task automatic check_model();
    chk("ev_valid", ev_valid, m_valid);
    if (m_valid) chk("ev_ch", ev_ch, m_ch);
    chk("overrun", overrun, m_ovr);
    chk("active", active, m_en);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_model();
    tick = 0; cfg_we = 0; clear_overrun = 0;
  endtask

  task automatic cfg(input int ch, input int per, input bit en);
    cfg_we = 1; cfg_ch = CH_W'(ch); cfg_period = PER_W'(per); cfg_enable = en;
    cycle();
  endtask

  task automatic do_reset();
    reset = 1;
    #1;
    chk("rst_valid", ev_valid, 0);
    chk("rst_ch", ev_ch, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_active", active, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset = 0;
  endtask

  initial begin
    reset = 1; tick = 0; cfg_we = 0; cfg_ch = '0; cfg_period = '0;
    cfg_enable = 0; clear_overrun = 0; ev_ready = 0;
    model_reset();
    do_reset();

    // Channel 1, period 3: event after ticks 3, 6 and 9, two edges after the tick.
    ev_ready = 1;
    cfg(1, 3, 1);
    for (int t = 1; t <= 9; t++) begin
      tick = 1; cycle(); cycle();
      chk("p3_valid", ev_valid, (t % 3) == 0);
      if ((t % 3) == 0) chk("p3_ch", ev_ch, 1);
      repeat (8) cycle();
    end

    // Channels 0 and 2 expire together: ch0 then ch2, twice.
    do_reset();
    ev_ready = 1;
    cfg(0, 1, 1);
    cfg(2, 1, 1);
    for (int r = 0; r < 2; r++) begin
      tick = 1; cycle(); cycle();
      chk("rr_first", {ev_valid, 30'd0, ev_ch}, {1'b1, 30'd0, 2'd0});
      cycle();
      chk("rr_second", {ev_valid, 30'd0, ev_ch}, {1'b1, 30'd0, 2'd2});
      cycle();
      chk("rr_idle", ev_valid, 0);
      repeat (5) cycle();
    end

    // Stalled consumer: offer held, re-pend, then overrun; clear; drain.
    do_reset();
    ev_ready = 0;
    cfg(0, 1, 1);
    tick = 1; cycle(); cycle();
    chk("stall_offer", {ev_valid, 30'd0, ev_ch}, {1'b1, 30'd0, 2'd0});
    repeat (3) cycle();
    tick = 1; cycle();
    chk("stall_no_ovr", overrun, 4'b0000);
    repeat (3) cycle();
    chk("stall_hold", {ev_valid, 30'd0, ev_ch}, {1'b1, 30'd0, 2'd0});
    tick = 1; cycle();
    chk("stall_ovr", overrun, 4'b0001);
    clear_overrun = 1; cycle();
    chk("ovr_clear", overrun, 4'b0000);
    ev_ready = 1; cycle();
    chk("drain_b2b", {ev_valid, 30'd0, ev_ch}, {1'b1, 30'd0, 2'd0});
    cycle();
    chk("drain_idle", ev_valid, 0);

    // cfg write on ch3 with count 1 in a tick cycle: no expiry, reload to 5.
    do_reset();
    ev_ready = 1;
    cfg(3, 2, 1);
    tick = 1; cycle();
    tick = 1; cfg_we = 1; cfg_ch = 2'd3; cfg_period = 8'd5; cfg_enable = 1;
    cycle(); cycle();
    chk("cfgtick_noexp", ev_valid, 0);
    for (int t = 1; t <= 5; t++) begin
      tick = 1; cycle(); cycle();
      chk("reload5", ev_valid, t == 5);
      repeat (2) cycle();
    end

    // Period 0 on ch2 fires on every tick.
    do_reset();
    ev_ready = 1;
    cfg(2, 0, 1);
    for (int r = 0; r < 3; r++) begin
      tick = 1; cycle(); cycle();
      chk("p0_event", {ev_valid, 30'd0, ev_ch}, {1'b1, 30'd0, 2'd2});
      cycle();
      chk("p0_idle", ev_valid, 0);
    end

    // Reset during an offer with an overrun set; no events afterwards.
    ev_ready = 0;
    tick = 1; cycle(); cycle();
    tick = 1; cycle();
    tick = 1; cycle();
    chk("pre_rst_ovr", {ev_valid, 27'd0, overrun}, {1'b1, 27'd0, 4'b0100});
    #2;
    do_reset();
    ev_ready = 1;
    for (int r = 0; r < 3; r++) begin
      tick = 1; cycle(); cycle();
      chk("post_rst_quiet", ev_valid, 0);
    end

    // Random traffic against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick          = ($urandom_range(0, 2) == 0);
      cfg_we        = ($urandom_range(0, 7) == 0);
      cfg_ch        = CH_W'($urandom_range(0, NUM_CH - 1));
      cfg_period    = PER_W'($urandom_range(0, 4));
      cfg_enable    = ($urandom_range(0, 3) != 0);
      clear_overrun = ($urandom_range(0, 15) == 0);
      ev_ready      = $urandom_range(0, 1);
      cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
